aud_adc_capture: RTL and testbench
==================================

Name: aud_adc_capture

Overview:
- Front-end capture stage that sits directly upstream of the echo record path.
- Receives the codec's I2S ADC stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT), which is asynchronous to clk.
- Synchronizes it into the clk domain and deserializes one channel into SAMPLE_W-bit words.
- Hands each word to the recorder with a valid/ready handshake and a sticky overrun flag.

Parameters:
- SAMPLE_W, 16: bits captured per frame, MSB first; legal range 8..32.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers; minimum 2.
- CHAN_SEL, 0: channel to capture. 0 = left (LRCK low), 1 = right (LRCK high).

Ports:
- clk  in  1  system clock; must be at least 8x BCLK.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  capture enable; level-sensitive.
- aud_bclk  in  1  codec bit clock, asynchronous to clk.
- aud_adclrck  in  1  codec LR clock, asynchronous to clk.
- aud_adcdat  in  1  codec serial ADC data.
- sample_data  out  SAMPLE_W  last accepted word, MSB-first assembled.
- sample_valid  out  1  sample_data holds an unconsumed word.
- sample_ready  in  1  consumer accepts the word.
- overrun  out  1  sticky flag: a completed word was dropped.
- frame_err  out  1  one-clk pulse when a frame is short and aborted.
- bit_out  out  1  serial sign-bit stream (optional feature).
- bit_strobe  out  1  qualifier for bit_out (optional feature).

Behaviour:
- Reset values: all outputs 0; shift register 0; bit counter 0; state IDLE.
- Synchronization: bclk, lrck and dat each pass through SYNC_STAGES flops.
- Bit event: a clk cycle in which synced bclk goes 0->1 (registered previous value 0, current 1). All sampling happens only on bit events.
- Frame boundary: lrck is sampled at each bit event and compared with its value at the previous bit event. A change to the CHAN_SEL level is a frame start.
- State IDLE:
  - Entered whenever en=0; en=0 takes priority over every other transition.
  - Clears the shift register, counter, sample_valid and overrun.
  - Exits to WAIT_FRAME when en=1.
- State WAIT_FRAME: on a frame-start bit event -> SKIP. This is the I2S one-BCLK delay; the data bit at that event is ignored.
- State SKIP: on the next bit event -> SHIFT. Capture of bit 0 (the MSB) happens on the bit event after that one.
- State SHIFT:
  - Each bit event does shift <= {shift[SAMPLE_W-2:0], dat} and cnt <= cnt+1.
  - When cnt reaches SAMPLE_W-1 and that bit is shifted in -> LOAD.
- Short frame: an lrck change seen in SHIFT before SAMPLE_W bits have been captured:
  - pulse frame_err for one clk and discard the partial word;
  - if the new lrck level equals CHAN_SEL -> SKIP, otherwise -> WAIT_FRAME.
- State LOAD (exactly 1 clk):
  - if sample_valid=0, or sample_valid=1 with sample_ready=1 in the same cycle: sample_data <= shift and sample_valid <= 1;
  - otherwise: keep the old word, set overrun.
  - Always -> WAIT_FRAME. Bits beyond SAMPLE_W in the frame are ignored.
- Handshake:
  - sample_valid falls on the clk after sample_valid & sample_ready, unless LOAD reloads in that same cycle.
  - sample_data is stable while sample_valid=1.
- overrun: sticky; cleared only by reset or en=0.
- Latency: sample_valid rises 2 clk after the bit event carrying the LSB, plus the synchronizer delay (SYNC_STAGES+1 clk from the pin edge).
- en dropped mid-frame: abort at the next clk; no partial word is ever presented.

Optional Feature:
- Macro: AUD_CAP_BITSTREAM_EN.
- Defined: on every successful LOAD, bit_out <= shift[SAMPLE_W-1] (sign bit) and bit_strobe pulses high for 1 clk. bit_out holds its value until the next LOAD. This gives a 1-bit/sample stream for the bit-serial recorder.
- Undefined: bit_out and bit_strobe are tied to 0 and the logic is not generated.

Decomposition:
- Package aud_pkg:
  - capture state enum (IDLE, WAIT_FRAME, SKIP, SHIFT, LOAD), 3-bit encoding;
  - AUD_SAMPLE_W_DEF=16;
  - AUD_I2S_DELAY=1;
  - CHAN_LEFT=0, CHAN_RIGHT=1.
- Sub-module aud_sync_edge: parameterized SYNC_STAGES synchronizer with registered rise/fall outputs. Instantiated for bclk (rise used) and lrck/dat (level only).

Test Plan:
- Reset/idle: rst low mid-run, en=0 -> all outputs 0; state IDLE; 1000 BCLK cycles produce no sample_valid.
- Basic capture: clk 50 MHz, BCLK 3.125 MHz, left word 16'hA5C3, right word 16'h1234, sample_ready=1 -> one sample_valid pulse per frame, sample_data=16'hA5C3; never 16'h1234.
- CHAN_SEL=1: same stimulus -> sample_data=16'h1234.
- Backpressure: sample_ready=0 across two frames with words 16'h0001, 16'h0002 -> sample_data stays 16'h0001 and overrun=1. Raising sample_ready then drops sample_valid; en low clears overrun.
- Short frame: LRCK toggles after 9 bits -> frame_err one-clk pulse, no sample_valid. The following full frame with 16'h7FFF is captured correctly.
- With AUD_CAP_BITSTREAM_EN defined: words 16'h8000, 16'h7FFF -> bit_strobe pulses twice, bit_out=1 then 0. With the macro undefined, both outputs stay 0.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared definitions for the audio ADC capture front-end.
// Capture FSM state encoding, default widths and channel codes.
package aud_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        SKIP       = 3'd2,
        SHIFT      = 3'd3,
        LOAD       = 3'd4
    } cap_state_t;

    localparam int AUD_SAMPLE_W_DEF = 16;
    localparam int AUD_I2S_DELAY    = 1;
    localparam int CHAN_LEFT        = 0;
    localparam int CHAN_RIGHT       = 1;

endpackage

// File: rtl/aud_sync_edge.sv
// Multi-flop synchronizer with registered level and edge outputs.
// Ports: clk, rst (async, active-low), d (async in), level, rise, fall.
module aud_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;

    // level, rise and fall all come out of the same register stage,
    // so an edge is flagged in the cycle the new level first appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], d};
            level <= sync[SYNC_STAGES-1];
            rise  <= sync[SYNC_STAGES-1] & ~level;
            fall  <= ~sync[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/aud_adc_capture.sv
// I2S ADC capture: syncs BCLK/LRCK/DAT, deserializes one channel MSB-first,
// and presents each word on a valid/ready port with a sticky overrun flag.
// Ports: clk, rst (async, active-low), en, aud_bclk, aud_adclrck,
//   aud_adcdat, sample_data/sample_valid/sample_ready, overrun, frame_err,
//   bit_out/bit_strobe (sign-bit stream, only with AUD_CAP_BITSTREAM_EN).
module aud_adc_capture
    import aud_pkg::*;
#(
    parameter int SAMPLE_W    = AUD_SAMPLE_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CHAN_SEL    = CHAN_LEFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                aud_bclk,
    input  logic                aud_adclrck,
    input  logic                aud_adcdat,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                frame_err,
    output logic                bit_out,
    output logic                bit_strobe
);

    localparam int   CW       = $clog2(SAMPLE_W);
    localparam logic CHAN_LVL = (CHAN_SEL == CHAN_RIGHT);

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lrck_s, lrck_rise, lrck_fall;
    logic dat_s, dat_rise, dat_fall;
    logic unused_sync;

    aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
        .clk(clk), .rst(rst), .d(aud_bclk),
        .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall)
    );

    aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
        .clk(clk), .rst(rst), .d(aud_adclrck),
        .level(lrck_s), .rise(lrck_rise), .fall(lrck_fall)
    );

    aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat (
        .clk(clk), .rst(rst), .d(aud_adcdat),
        .level(dat_s), .rise(dat_rise), .fall(dat_fall)
    );

    assign unused_sync = ^{bclk_lvl, bclk_fall, lrck_rise,
                           lrck_fall, dat_rise, dat_fall};

    cap_state_t          state, state_nx;
    logic [SAMPLE_W-1:0] shift;
    logic [CW-1:0]       cnt;
    logic                lrck_prev;
    logic                lrck_chg;
    logic                frame_start;
    logic                do_shift;
    logic                short_frame;
    logic                load_ok;

    // LRCK is only compared between bit events, never clk to clk.
    assign lrck_chg    = bclk_rise & (lrck_s != lrck_prev);
    assign frame_start = lrck_chg & (lrck_s == CHAN_LVL);
    assign load_ok     = ~sample_valid | sample_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lrck_prev <= 1'b0;
        end else if (bclk_rise) begin
            lrck_prev <= lrck_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        do_shift    = 1'b0;
        short_frame = 1'b0;
        unique case (state)
            IDLE:       state_nx = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) state_nx = SKIP;
            SKIP:       if (bclk_rise) state_nx = SHIFT;
            SHIFT: begin
                if (lrck_chg) begin
                    short_frame = 1'b1;
                    state_nx    = (lrck_s == CHAN_LVL) ? SKIP : WAIT_FRAME;
                end else if (bclk_rise) begin
                    do_shift = 1'b1;
                    if (cnt == CW'(SAMPLE_W - 1)) state_nx = LOAD;
                end
            end
            LOAD:       state_nx = WAIT_FRAME;
            default:    state_nx = IDLE;
        endcase
        if (!en) begin
            state_nx    = IDLE;
            do_shift    = 1'b0;
            short_frame = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift        <= '0;
            cnt          <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else if (!en || state == IDLE) begin
            shift        <= '0;
            cnt          <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= short_frame;
            if (do_shift) begin
                shift <= {shift[SAMPLE_W-2:0], dat_s};
                cnt   <= cnt + CW'(1);
            end else if (state != SHIFT) begin
                cnt <= '0;
            end
            if (state == LOAD) begin
                if (load_ok) begin
                    sample_data  <= shift;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef AUD_CAP_BITSTREAM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_out    <= 1'b0;
            bit_strobe <= 1'b0;
        end else if (!en) begin
            bit_strobe <= 1'b0;
        end else begin
            bit_strobe <= (state == LOAD) && load_ok;
            if (state == LOAD && load_ok) begin
                bit_out <= shift[SAMPLE_W-1];
            end
        end
    end
`else
    assign bit_out    = 1'b0;
    assign bit_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_aud_adc_capture.sv
// Scoreboard bench for aud_adc_capture: left and right channel instances,
// I2S frames driven directly, words checked by a separate monitor.
module tb_aud_adc_capture;

    logic        clk;
    logic        rst;
    logic        en;
    logic        bclk;
    logic        lrck;
    logic        dat;
    logic        rdy_l;
    logic        rdy_r;
    logic [15:0] data_l, data_r;
    logic        vl_l, vl_r;
    logic        ov_l, ov_r;
    logic        fe_l, fe_r;
    logic        bo_l, bo_r;
    logic        bs_l, bs_r;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    logic        b_l[$];
    logic        b_r[$];
    int nexp_l = 0;
    int nexp_r = 0;

    int vcnt   = 0;
    int fe_l_hi = 0, fe_l_p = 0, fe_r_p = 0;
    int bs_hi_l = 0, bs_hi_r = 0, bs_bad = 0;
    logic fe_l_d = 1'b0, fe_r_d = 1'b0;
    int v0;

    aud_adc_capture #(.SAMPLE_W(16), .SYNC_STAGES(2), .CHAN_SEL(0)) dut_l (
        .clk(clk), .rst(rst), .en(en),
        .aud_bclk(bclk), .aud_adclrck(lrck), .aud_adcdat(dat),
        .sample_data(data_l), .sample_valid(vl_l), .sample_ready(rdy_l),
        .overrun(ov_l), .frame_err(fe_l),
        .bit_out(bo_l), .bit_strobe(bs_l)
    );

    aud_adc_capture #(.SAMPLE_W(16), .SYNC_STAGES(2), .CHAN_SEL(1)) dut_r (
        .clk(clk), .rst(rst), .en(en),
        .aud_bclk(bclk), .aud_adclrck(lrck), .aud_adcdat(dat),
        .sample_data(data_r), .sample_valid(vl_r), .sample_ready(rdy_r),
        .overrun(ov_r), .frame_err(fe_r),
        .bit_out(bo_r), .bit_strobe(bs_r)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic exp_l(input logic [15:0] w);
        q_l.push_back(w);
        b_l.push_back(w[15]);
        nexp_l++;
    endtask

    task automatic exp_r(input logic [15:0] w);
        q_r.push_back(w);
        b_r.push_back(w[15]);
        nexp_r++;
    endtask

    // One LRCK half: MSB sits on the third BCLK rise after the LRCK edge.
    task automatic send_half(input logic lr, input logic [15:0] w,
                             input int nbclk, input int nbits);
        for (int k = 0; k < nbclk; k++) begin
            bclk = 1'b0;
            if (k == 0) lrck = lr;
            dat = (k >= 2 && (k - 2) < nbits) ? w[15-(k-2)] : 1'b0;
            #160;
            bclk = 1'b1;
            #160;
        end
    endtask

    task automatic send_frame(input logic [15:0] wl, input logic [15:0] wr);
        send_half(1'b0, wl, 20, 16);
        send_half(1'b1, wr, 20, 16);
    endtask

    task automatic chk_zero();
        chk("rst_data_l", data_l, 0);
        chk("rst_valid_l", vl_l, 0);
        chk("rst_ovr_l", ov_l, 0);
        chk("rst_ferr_l", fe_l, 0);
        chk("rst_bout_l", bo_l, 0);
        chk("rst_bstb_l", bs_l, 0);
        chk("rst_data_r", data_r, 0);
        chk("rst_valid_r", vl_r, 0);
        chk("rst_ovr_r", ov_r, 0);
        chk("rst_ferr_r", fe_r, 0);
        chk("rst_bout_r", bo_r, 0);
        chk("rst_bstb_r", bs_r, 0);
    endtask

    initial begin
        logic [15:0] w;
        logic        b;
        forever begin
            @(negedge clk);
            if (vl_l || vl_r) vcnt++;
            if (vl_l && rdy_l) begin
                if (q_l.size() == 0) begin
                    chk("left_unexpected", data_l, 16'hxxxx);
                end else begin
                    w = q_l.pop_front();
                    chk("left_word", data_l, w);
                end
            end
            if (vl_r && rdy_r) begin
                if (q_r.size() == 0) begin
                    chk("right_unexpected", data_r, 16'hxxxx);
                end else begin
                    w = q_r.pop_front();
                    chk("right_word", data_r, w);
                end
            end
            if (fe_l) fe_l_hi++;
            if (fe_l && !fe_l_d) fe_l_p++;
            if (fe_r && !fe_r_d) fe_r_p++;
            fe_l_d = fe_l;
            fe_r_d = fe_r;
`ifdef AUD_CAP_BITSTREAM_EN
            if (bs_l) begin
                bs_hi_l++;
                if (b_l.size() == 0) begin
                    chk("left_bit_unexpected", bs_l, 0);
                end else begin
                    b = b_l.pop_front();
                    chk("left_bit", bo_l, b);
                end
            end
            if (bs_r) begin
                bs_hi_r++;
                if (b_r.size() == 0) begin
                    chk("right_bit_unexpected", bs_r, 0);
                end else begin
                    b = b_r.pop_front();
                    chk("right_bit", bo_r, b);
                end
            end
`else
            if (bs_l || bo_l || bs_r || bo_r) bs_bad++;
`endif
        end
    end

    initial begin
        rst   = 1'b0;
        en    = 1'b0;
        bclk  = 1'b0;
        lrck  = 1'b1;
        dat   = 1'b0;
        rdy_l = 1'b1;
        rdy_r = 1'b1;
        #53;
        chk_zero();
        rst = 1'b1;
        #100;

        // en low: 25 frames = 1000 BCLK cycles, nothing may appear
        v0 = vcnt;
        for (int i = 0; i < 25; i++) send_frame(16'hA5C3, 16'h1234);
        chk("idle_no_valid", vcnt, v0);

        // basic capture on both channel selections
        en = 1'b1;
        #100;
        for (int i = 0; i < 3; i++) begin
            exp_l(16'hA5C3);
            exp_r(16'h1234);
            send_frame(16'hA5C3, 16'h1234);
        end
        chk("basic_l_drained", q_l.size(), 0);
        chk("basic_r_drained", q_r.size(), 0);

        // backpressure: second left word is dropped
        rdy_l = 1'b0;
        exp_l(16'h0001);
        exp_r(16'h1111);
        send_frame(16'h0001, 16'h1111);
        exp_r(16'h2222);
        send_frame(16'h0002, 16'h2222);
        #100;
        chk("bp_data_held", data_l, 16'h0001);
        chk("bp_valid_held", vl_l, 1);
        chk("bp_overrun", ov_l, 1);
        chk("bp_r_no_ovr", ov_r, 0);
        rdy_l = 1'b1;
        #200;
        chk("bp_valid_drop", vl_l, 0);
        chk("bp_ovr_sticky", ov_l, 1);
        chk("bp_l_drained", q_l.size(), 0);
        en = 1'b0;
        #100;
        chk("en_clears_ovr", ov_l, 0);

        // reset asserted in the middle of a frame
        en = 1'b1;
        #100;
        fork
            send_frame(16'hAAAA, 16'hBBBB);
            begin
                #2000;
                rst = 1'b0;
                en  = 1'b0;
                #100;
                chk_zero();
                #100;
                rst = 1'b1;
            end
        join

        // short left frame (9 bits), then full frames
        en = 1'b1;
        #100;
        send_half(1'b0, 16'hFFFF, 11, 9);
        exp_r(16'h5A5A);
        send_half(1'b1, 16'h5A5A, 20, 16);
        exp_l(16'h7FFF);
        exp_r(16'h0F0F);
        send_frame(16'h7FFF, 16'h0F0F);
        chk("short_ferr_pulses", fe_l_p, 1);
        chk("short_ferr_width", fe_l_hi, 1);
        chk("short_r_no_ferr", fe_r_p, 0);

        // sign-bit stream words
        exp_l(16'h8000);
        exp_r(16'h8001);
        send_frame(16'h8000, 16'h8001);
        exp_l(16'h7FFF);
        exp_r(16'h7001);
        send_frame(16'h7FFF, 16'h7001);

        #500;
        chk("end_l_drained", q_l.size(), 0);
        chk("end_r_drained", q_r.size(), 0);
`ifdef AUD_CAP_BITSTREAM_EN
        chk("bits_l_drained", b_l.size(), 0);
        chk("bits_r_drained", b_r.size(), 0);
        chk("strobe_l_cycles", bs_hi_l, nexp_l);
        chk("strobe_r_cycles", bs_hi_r, nexp_r);
`else
        chk("bitstream_tied_low", bs_bad, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
